// File: rtl/feedback_receiver.sv
// UART receiver (8N1, LSB first) for the kitchen-game host link with traveler
// feedback decoding into registered status flags and a staleness watchdog.
module feedback_receiver #(
    parameter int unsigned CLK_FREQ     = 100_000_000,
    parameter int unsigned BAUD         = 115200,
    parameter int unsigned STALE_CYCLES = 10_000_000
) (
    input  logic       clk,
    input  logic       res,
    input  logic       uart_rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       sig_front,
    output logic       sig_hand,
    output logic       sig_processing,
    output logic       sig_machine,
    output logic       fb_update,
    output logic       fb_stale
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned STALE_W      = $clog2(STALE_CYCLES + 1);

    localparam logic [CNT_W-1:0]   CNT_HALF   = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [STALE_W-1:0] STALE_MAX  = STALE_W'(STALE_CYCLES);
    localparam logic [STALE_W-1:0] STALE_LAST = STALE_W'(STALE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rx_s;
    logic [CNT_W-1:0]     cnt;
    logic [2:0]           bit_idx;
    logic [7:0]           shreg;
    logic [STALE_W-1:0]   stale_cnt;
    logic                 fb_hit;

    assign fb_hit = rx_valid && (rx_byte[7:6] == 2'b00) && (rx_byte[1:0] == 2'b01);

    always_ff @(posedge clk) begin
        if (res) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == CNT_FULL) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt == CNT_FULL) begin
                        cnt   <= '0;
                        state <= IDLE;
                        if (rx_s) begin
                            rx_byte  <= shreg;
                            rx_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // fb_stale is sticky from reset until the first feedback byte, then tracks saturation
    always_ff @(posedge clk) begin
        if (res) begin
            sig_front      <= 1'b0;
            sig_hand       <= 1'b0;
            sig_processing <= 1'b0;
            sig_machine    <= 1'b0;
            fb_update      <= 1'b0;
            fb_stale       <= 1'b1;
            stale_cnt      <= '0;
        end else begin
            fb_update <= 1'b0;
            if (fb_hit) begin
                sig_front      <= rx_byte[2];
                sig_hand       <= rx_byte[3];
                sig_processing <= rx_byte[4];
                sig_machine    <= rx_byte[5];
                fb_update      <= 1'b1;
                stale_cnt      <= '0;
                fb_stale       <= 1'b0;
            end else if (stale_cnt != STALE_MAX) begin
                stale_cnt <= stale_cnt + STALE_W'(1);
                if (stale_cnt == STALE_LAST) fb_stale <= 1'b1;
            end else begin
                fb_stale <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_feedback_receiver.sv
// Directed bench for feedback_receiver: 10 clocks per bit, 500-cycle stale limit.
module tb_feedback_receiver;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       uart_rx = 1'b1;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_err;
    logic       sig_front;
    logic       sig_hand;
    logic       sig_processing;
    logic       sig_machine;
    logic       fb_update;
    logic       fb_stale;

    int checks = 0;
    int errors = 0;

    int          cyc = 0;
    int          rv_q[$];
    logic [7:0]  rvb_q[$];
    int          fb_q[$];
    logic [3:0]  fbf_q[$];
    logic        fbs_q[$];
    int          fe_cnt = 0;
    int          viol = 0;

    feedback_receiver #(
        .CLK_FREQ    (1_000_000),
        .BAUD        (100_000),
        .STALE_CYCLES(500)
    ) dut (
        .clk           (clk),
        .res           (res),
        .uart_rx       (uart_rx),
        .rx_byte       (rx_byte),
        .rx_valid      (rx_valid),
        .frame_err     (frame_err),
        .sig_front     (sig_front),
        .sig_hand      (sig_hand),
        .sig_processing(sig_processing),
        .sig_machine   (sig_machine),
        .fb_update     (fb_update),
        .fb_stale      (fb_stale)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] flags();
        return {sig_machine, sig_processing, sig_hand, sig_front};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        logic prv, pfe, pfb;
        prv = 1'b0;
        pfe = 1'b0;
        pfb = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_valid === 1'b1) begin
                rv_q.push_back(cyc);
                rvb_q.push_back(rx_byte);
            end
            if (fb_update === 1'b1) begin
                fb_q.push_back(cyc);
                fbf_q.push_back(flags());
                fbs_q.push_back(fb_stale);
            end
            if (frame_err === 1'b1) fe_cnt++;
            if ((rx_valid && prv) || (frame_err && pfe) || (fb_update && pfb) || (rx_valid && frame_err))
                viol++;
            prv = rx_valid;
            pfe = frame_err;
            pfb = fb_update;
        end
    end

    initial begin
        #200_000;
        $display("FAIL timeout got %0d expected finish", cyc);
        $fatal(1, "bench timeout");
    end

    // rst_bit indexes the 10-bit frame (0 = start bit); -1 means no reset pulse
    task automatic send_frame(input logic [7:0] data, input logic stop, input int rst_bit);
        logic [9:0] bits;
        bits = {stop, data, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = bits[i];
            for (int c = 0; c < 10; c++) begin
                if (i == rst_bit && c == 4) res = 1'b1;
                if (i == rst_bit && c == 5) begin
                    res = 1'b0;
                    check("midrst_flags", 32'(flags()), 32'h0);
                    check("midrst_stale", 32'(fb_stale), 32'h1);
                    check("midrst_valid", 32'(rx_valid), 32'h0);
                end
                @(negedge clk);
            end
        end
        uart_rx = 1'b1;
    endtask

    initial begin
        int n_fb;
        int mark_rv;
        int mark_fb;
        int bad;

        repeat (3) @(negedge clk);
        check("rst_flags", 32'(flags()), 32'h0);
        check("rst_valid", 32'(rx_valid), 32'h0);
        check("rst_byte", 32'(rx_byte), 32'h0);
        check("rst_stale", 32'(fb_stale), 32'h1);
        res = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_stale", 32'(fb_stale), 32'h1);

        send_frame(8'h3D, 1'b1, -1);
        send_frame(8'h15, 1'b1, -1);
        repeat (20) @(negedge clk);
        check("b2b_rv_count", 32'(rv_q.size()), 32'd2);
        check("b2b_byte0", 32'(rvb_q[0]), 32'h3D);
        check("b2b_byte1", 32'(rvb_q[1]), 32'h15);
        check("b2b_spacing", 32'(rv_q[1] - rv_q[0]), 32'd100);
        check("b2b_fb_count", 32'(fb_q.size()), 32'd2);
        check("fb0_latency", 32'(fb_q[0] - rv_q[0]), 32'd1);
        check("fb0_flags", 32'(fbf_q[0]), 32'hF);
        check("fb0_stale", 32'(fbs_q[0]), 32'h0);
        check("fb1_latency", 32'(fb_q[1] - rv_q[1]), 32'd1);
        check("fb1_flags", 32'(fbf_q[1]), 32'h5);
        check("fb1_stale", 32'(fbs_q[1]), 32'h0);
        n_fb = fb_q[1];

        send_frame(8'h82, 1'b1, -1);
        repeat (20) @(negedge clk);
        check("nonfb_rv_count", 32'(rv_q.size()), 32'd3);
        check("nonfb_byte", 32'(rx_byte), 32'h82);
        check("nonfb_fb_count", 32'(fb_q.size()), 32'd2);
        check("nonfb_flags", 32'(flags()), 32'h5);

        while (cyc < n_fb + 499) @(negedge clk);
        check("stale_before", 32'(fb_stale), 32'h0);
        @(negedge clk);
        check("stale_at", 32'(fb_stale), 32'h1);
        check("stale_flags", 32'(flags()), 32'h5);

        send_frame(8'h3D, 1'b0, -1);
        repeat (30) @(negedge clk);
        check("ferr_count", 32'(fe_cnt), 32'd1);
        check("ferr_rv_count", 32'(rv_q.size()), 32'd3);
        check("ferr_byte", 32'(rx_byte), 32'h82);
        check("ferr_flags", 32'(flags()), 32'h5);
        check("ferr_stale", 32'(fb_stale), 32'h1);

        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_rv_count", 32'(rv_q.size()), 32'd3);
        check("glitch_fe_count", 32'(fe_cnt), 32'd1);
        send_frame(8'hA5, 1'b1, -1);
        repeat (20) @(negedge clk);
        check("post_glitch_byte", 32'(rx_byte), 32'hA5);
        check("post_glitch_rv", 32'(rv_q.size()), 32'd4);
        check("post_glitch_fb", 32'(fb_q.size()), 32'd2);

        mark_rv = rv_q.size();
        mark_fb = fb_q.size();
        send_frame(8'h3D, 1'b1, 5);
        repeat (150) @(negedge clk);
        bad = 0;
        for (int i = mark_rv; i < rv_q.size(); i++)
            if (rvb_q[i] == 8'h3D) bad++;
        check("abort_no_3d", 32'(bad), 32'd0);
        check("abort_no_fb", 32'(fb_q.size() - mark_fb), 32'd0);
        check("abort_flags", 32'(flags()), 32'h0);

        send_frame(8'h05, 1'b1, -1);
        repeat (20) @(negedge clk);
        check("rec_byte", 32'(rx_byte), 32'h05);
        check("rec_fb_count", 32'(fb_q.size() - mark_fb), 32'd1);
        check("rec_flags", 32'(flags()), 32'h1);
        check("rec_stale", 32'(fb_stale), 32'h0);
        check("pulse_rules", 32'(viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
